fan_ctrl: RTL and testbench

// - Closed-loop fan controller sitting on the shared 5-bit CSR bus next to pwm/gpio; drives duty/enable of a pwm engine.
// - Measures tach pulses per 1 s window, sequences spin-up, regulates speed to a target (AUTO) or applies a manual duty.
// - Detects stalled fans, retries spin-up, raises a level interrupt ORed into the board interrupt line.

---
 rtl/fan_ctrl_pkg.sv | 52 +++++
 rtl/fan_ctrl_tach.sv | 51 +++++
 rtl/fan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_fan_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the fan controller: CSR map, CTRL bit positions, tuning constants,
// FSM state encoding and the AUTO-mode duty step helper.
package fan_ctrl_pkg;

    localparam logic [4:0] BASE_ADDR  = 5'h1a;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DUTY   = 2'd1;
    localparam logic [1:0] REG_TARGET = 2'd2;
    localparam logic [1:0] REG_TACH   = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_STALL = 2;
    localparam int CTRL_IE    = 3;

    localparam logic [1:0] SPINUP_WIN = 2'd2;
    localparam logic [1:0] STALL_WIN  = 2'd3;
    localparam logic [7:0] MIN_DUTY   = 8'h40;
    localparam logic [7:0] STEP       = 8'h08;
    localparam logic [7:0] HYST       = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPINUP = 2'd1,
        ST_RUN    = 2'd2
    } fan_state_e;

    // One AUTO regulation step; all comparisons in 9 bits so nothing wraps.
    function automatic logic [7:0] auto_step(input logic [7:0] duty,
                                             input logic [7:0] tach,
                                             input logic [7:0] target);
        logic [8:0] lo_s;
        logic [8:0] hi_s;
        logic [8:0] up_s;
        lo_s = {1'b0, tach} + {1'b0, HYST};
        hi_s = {1'b0, target} + {1'b0, HYST};
        if (hi_s > 9'd255) begin
            hi_s = 9'd255;
        end else begin
            hi_s = hi_s;
        end
        up_s = {1'b0, duty} + {1'b0, STEP};
        if (lo_s < {1'b0, target}) begin
            auto_step = (up_s > 9'd255) ? 8'hff : up_s[7:0];
        end else if ({1'b0, tach} > hi_s) begin
            auto_step = ({1'b0, duty} >= ({1'b0, MIN_DUTY} + {1'b0, STEP})) ? (duty - STEP) : MIN_DUTY;
        end else begin
            auto_step = duty;
        end
    endfunction

endpackage

// File: rtl/fan_ctrl_tach.sv
// Tach front end: 2-flop synchronizer, falling-edge detect at the ce_32khz sample rate,
// saturating pulse counter and per-window latch.
module fan_tach (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_32khz,
    input  logic       ce_1s,
    input  logic       tach_in,
    output logic [7:0] tach_cnt
);

    logic       sync1_r;
    logic       sync2_r;
    logic       samp_r;
    logic [7:0] cnt_r;
    logic [7:0] tach_cnt_r;
    logic       fall_s;
    logic [7:0] cnt_next_s;

    // Edge between consecutive samples; the count includes an edge landing in the window-close cycle.
    always_comb begin
        fall_s     = ce_32khz && samp_r && !sync2_r;
        cnt_next_s = (fall_s && (cnt_r != 8'hff)) ? (cnt_r + 8'd1) : cnt_r;
    end

    // Synchronizer, sample register, counter and window latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            samp_r     <= 1'b0;
            cnt_r      <= 8'h00;
            tach_cnt_r <= 8'h00;
        end else begin
            sync1_r <= tach_in;
            sync2_r <= sync1_r;
            if (ce_32khz) begin
                samp_r <= sync2_r;
            end
            if (ce_1s) begin
                tach_cnt_r <= cnt_next_s;
                cnt_r      <= 8'h00;
            end else begin
                cnt_r <= cnt_next_s;
            end
        end
    end

    assign tach_cnt = tach_cnt_r;

endmodule

// File: rtl/fan_ctrl.sv
// Closed-loop fan controller: CSR block, spin-up/run sequencing, AUTO duty regulation,
// stall detection with retry and level interrupt.
module fan_ctrl
    import fan_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_32khz,
    input  logic       ce_1s,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic       tach_in,
    output logic [7:0] pwm_duty,
    output logic       pwm_en,
    output logic       irq
);

    fan_state_e state_r;
    logic       ie_r;
    logic       stall_r;
    logic       auto_r;
    logic       en_r;
    logic [7:0] duty_reg_r;
    logic [7:0] target_r;
    logic [7:0] pwm_duty_r;
    logic       pwm_en_r;
    logic       irq_r;
    logic [1:0] spin_cnt_r;
    logic [1:0] zero_cnt_r;
    logic       run_win_r;
    logic [7:0] tach_s;
    logic [4:0] off_s;
    logic       hit_s;
    logic [7:0] rd_s;
    logic       ctrl_wr_s;
    logic       duty_wr_s;
    logic       target_wr_s;
    logic       en_clear_s;
    logic       stall_set_s;

    fan_tach u_tach (
        .clk      (clk),
        .rst      (rst),
        .ce_32khz (ce_32khz),
        .ce_1s    (ce_1s),
        .tach_in  (tach_in),
        .tach_cnt (tach_s)
    );

    // Address decode and write strobes; offsets below BASE_ADDR wrap high and miss.
    always_comb begin
        off_s       = csr_a - BASE_ADDR;
        hit_s       = (off_s < 5'd4);
        ctrl_wr_s   = csr_we && hit_s && (off_s[1:0] == REG_CTRL);
        duty_wr_s   = csr_we && hit_s && (off_s[1:0] == REG_DUTY);
        target_wr_s = csr_we && hit_s && (off_s[1:0] == REG_TARGET);
        en_clear_s  = ctrl_wr_s && !csr_di[CTRL_EN];
        stall_set_s = (state_r == ST_RUN) && run_win_r && (tach_s == 8'h00)
                      && (zero_cnt_r == (STALL_WIN - 2'd1)) && !en_clear_s;
    end

    // Read mux; the bus is ORed with other peripherals so misses return zero.
    always_comb begin
        rd_s = 8'h00;
        if (hit_s) begin
            case (off_s[1:0])
                REG_CTRL:   rd_s = {4'b0000, ie_r, stall_r, auto_r, en_r};
                REG_DUTY:   rd_s = pwm_duty_r;
                REG_TARGET: rd_s = target_r;
                REG_TACH:   rd_s = tach_s;
                default:    rd_s = 8'h00;
            endcase
        end else begin
            rd_s = 8'h00;
        end
    end

    assign csr_do = rd_s;

    // Control/config registers; a stall detected in the same cycle as a W1C survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_r       <= 1'b0;
            stall_r    <= 1'b0;
            auto_r     <= 1'b0;
            en_r       <= 1'b0;
            duty_reg_r <= 8'h00;
            target_r   <= 8'h00;
            irq_r      <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                ie_r   <= csr_di[CTRL_IE];
                auto_r <= csr_di[CTRL_AUTO];
                en_r   <= csr_di[CTRL_EN];
            end
            if (stall_set_s) begin
                stall_r <= 1'b1;
            end else if (ctrl_wr_s && csr_di[CTRL_STALL]) begin
                stall_r <= 1'b0;
            end
            if (duty_wr_s) begin
                duty_reg_r <= csr_di;
            end
            if (target_wr_s) begin
                target_r <= csr_di;
            end
            irq_r <= stall_r & ie_r;
        end
    end

    // Marks the cycle after a window closed while running, when the new TACH value is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_win_r <= 1'b0;
        end else begin
            run_win_r <= ce_1s && (state_r == ST_RUN);
        end
    end

    // Sequencer with registered pwm outputs; an EN=0 write overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pwm_duty_r <= 8'h00;
            pwm_en_r   <= 1'b0;
            spin_cnt_r <= 2'd0;
            zero_cnt_r <= 2'd0;
        end else if (en_clear_s) begin
            state_r    <= ST_IDLE;
            pwm_duty_r <= 8'h00;
            pwm_en_r   <= 1'b0;
            spin_cnt_r <= 2'd0;
            zero_cnt_r <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pwm_duty_r <= 8'h00;
                    pwm_en_r   <= 1'b0;
                    zero_cnt_r <= 2'd0;
                    spin_cnt_r <= 2'd0;
                    if (en_r) begin
                        state_r    <= ST_SPINUP;
                        pwm_duty_r <= 8'hff;
                        pwm_en_r   <= 1'b1;
                    end
                end
                ST_SPINUP: begin
                    pwm_duty_r <= 8'hff;
                    pwm_en_r   <= 1'b1;
                    zero_cnt_r <= 2'd0;
                    if (ce_1s) begin
                        if (spin_cnt_r == (SPINUP_WIN - 2'd1)) begin
                            state_r    <= ST_RUN;
                            pwm_duty_r <= duty_reg_r;
                            spin_cnt_r <= 2'd0;
                        end else begin
                            spin_cnt_r <= spin_cnt_r + 2'd1;
                        end
                    end
                end
                ST_RUN: begin
                    pwm_en_r <= 1'b1;
                    if (stall_set_s) begin
                        state_r    <= ST_SPINUP;
                        pwm_duty_r <= 8'hff;
                        spin_cnt_r <= 2'd0;
                        zero_cnt_r <= 2'd0;
                    end else begin
                        if (run_win_r) begin
                            zero_cnt_r <= (tach_s == 8'h00) ? (zero_cnt_r + 2'd1) : 2'd0;
                        end
                        if (duty_wr_s) begin
                            pwm_duty_r <= csr_di;
                        end else if (!auto_r) begin
                            pwm_duty_r <= duty_reg_r;
                        end else if (run_win_r) begin
                            pwm_duty_r <= auto_step(pwm_duty_r, tach_s, target_r);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    pwm_duty_r <= 8'h00;
                    pwm_en_r   <= 1'b0;
                    spin_cnt_r <= 2'd0;
                    zero_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign pwm_duty = pwm_duty_r;
    assign pwm_en   = pwm_en_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_fan_ctrl.sv
// Randomised bench for fan_ctrl: per-window expectations come from a behavioural model
// and are checked by a monitor a few cycles after each ce_1s strobe.
module tb_fan_ctrl;

    localparam logic [4:0] BASE = 5'h1a;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce_32khz = 1'b0;
    logic       ce_1s = 1'b0;
    logic [4:0] csr_a = 5'h00;
    logic [7:0] csr_di = 8'h00;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    logic       tach_in = 1'b1;
    logic [7:0] pwm_duty;
    logic       pwm_en;
    logic       irq;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int tach;
        int duty;
        int en;
        int irq;
    } exp_t;
    exp_t exp_q[$];

    // model state: mode 0=off, 1=spinning up, 2=running
    int m_mode, m_wins, m_zero, m_duty_reg, m_target, m_applied;
    bit m_en, m_auto, m_ie, m_stall;

    fan_ctrl dut (
        .clk(clk), .rst(rst), .ce_32khz(ce_32khz), .ce_1s(ce_1s),
        .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we), .csr_do(csr_do),
        .tach_in(tach_in), .pwm_duty(pwm_duty), .pwm_en(pwm_en), .irq(irq)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        ce_32khz = ~ce_32khz;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void m_reset();
        m_mode = 0; m_wins = 0; m_zero = 0; m_duty_reg = 0; m_target = 0; m_applied = 0;
        m_en = 0; m_auto = 0; m_ie = 0; m_stall = 0;
    endfunction

    function automatic void m_write(input int off, input int d, input bit just_set);
        if (off == 0) begin
            m_ie = d[3]; m_auto = d[1]; m_en = d[0];
            if (d[2] && !just_set) m_stall = 0;
            if (!m_en) begin
                m_mode = 0; m_zero = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_wins = 0;
            end
            if (m_mode == 2 && !m_auto) m_applied = m_duty_reg;
        end else if (off == 1) begin
            m_duty_reg = d;
            if (m_mode == 2) m_applied = d;
        end else if (off == 2) begin
            m_target = d;
        end
    endfunction

    function automatic bit m_window(input int tach);
        bit set = 0;
        if (m_mode == 1) begin
            m_wins++;
            if (m_wins == 2) begin
                m_mode = 2; m_applied = m_duty_reg;
            end
        end else if (m_mode == 2) begin
            m_zero = (tach == 0) ? m_zero + 1 : 0;
            if (m_zero == 3) begin
                m_stall = 1; m_mode = 1; m_wins = 0; m_zero = 0; set = 1;
            end else if (m_auto) begin
                int hi = (m_target + 2 > 255) ? 255 : m_target + 2;
                if (tach + 2 < m_target) m_applied = (m_applied + 8 > 255) ? 255 : m_applied + 8;
                else if (tach > hi) m_applied = (m_applied - 8 < 64) ? 64 : m_applied - 8;
            end
        end
        return set;
    endfunction

    task automatic csr_wr(input int off, input int d);
        @(negedge clk);
        csr_a = BASE + 5'(off); csr_di = 8'(d); csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0; csr_a = BASE + 5'd3;
        m_write(off, d, 1'b0);
    endtask

    task automatic csr_rd_chk(input string name, input logic [4:0] addr, input int req);
        @(negedge clk);
        csr_a = addr;
        #1;
        chk(name, int'(csr_do), req);
        csr_a = BASE + 5'd3;
    endtask

    // n tach pulses, then a window strobe; wmode 1 writes during the strobe, 2 the cycle after
    task automatic window(input int n, input int wmode, input int woff, input int wd);
        exp_t e;
        bit js;
        int t;
        for (int i = 0; i < n; i++) begin
            tach_in = 1'b0;
            repeat (3) @(negedge clk);
            tach_in = 1'b1;
            repeat (3) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        t = (n > 255) ? 255 : n;
        if (wmode == 1) begin
            m_write(woff, wd, 1'b0);
            js = m_window(t);
        end else begin
            js = m_window(t);
            if (wmode == 2) m_write(woff, wd, js);
        end
        e.tach = t;
        e.duty = (m_mode == 0) ? 0 : (m_mode == 1) ? 255 : m_applied;
        e.en   = (m_mode != 0) ? 1 : 0;
        e.irq  = (m_stall && m_ie) ? 1 : 0;
        exp_q.push_back(e);
        csr_a = BASE + 5'd3;
        ce_1s = 1'b1;
        if (wmode == 1) begin
            csr_a = BASE + 5'(woff); csr_di = 8'(wd); csr_we = 1'b1;
        end
        @(negedge clk);
        ce_1s = 1'b0; csr_we = 1'b0; csr_a = BASE + 5'd3;
        if (wmode == 2) begin
            csr_a = BASE + 5'(woff); csr_di = 8'(wd); csr_we = 1'b1;
            @(negedge clk);
            csr_we = 1'b0; csr_a = BASE + 5'd3;
        end
        repeat (6) @(negedge clk);
    endtask

    // Monitor: each window result is checked three cycles after its strobe.
    initial forever begin
        exp_t e;
        @(posedge clk iff ce_1s === 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("window_without_expectation", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("win_tach", int'(csr_do), e.tach);
            chk("win_duty", int'(pwm_duty), e.duty);
            chk("win_pwm_en", int'(pwm_en), e.en);
            chk("win_irq", int'(irq), e.irq);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) csr_rd_chk("reset_reg", BASE + 5'(i), 0);
        csr_rd_chk("reset_unmapped", 5'h00, 0);
        csr_rd_chk("unmapped_above", 5'h1e, 0);
        chk("reset_pwm_en", int'(pwm_en), 0);
        chk("reset_pwm_duty", int'(pwm_duty), 0);
        chk("reset_irq", int'(irq), 0);

        // spin-up then manual run
        csr_wr(1, 8'h80);
        csr_wr(0, 8'h01);
        repeat (3) @(negedge clk);
        chk("spinup_duty", int'(pwm_duty), 8'hff);
        chk("spinup_en", int'(pwm_en), 1);
        window(37, 0, 0, 0);
        window(300, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(1, 0) == 1) csr_wr(1, $urandom_range(255, 0));
            window($urandom_range(120, 1), 0, 0, 0);
        end

        // AUTO regulation: up, down to the floor, hold in the dead band
        csr_wr(2, 64);
        csr_wr(1, 8'h80);
        csr_wr(0, 8'h03);
        csr_rd_chk("ctrl_auto", BASE, 8'h03);
        for (int i = 0; i < 3; i++) window(40, 0, 0, 0);
        for (int i = 0; i < 12; i++) window(100, 0, 0, 0);
        for (int i = 0; i < 2; i++) window(65, 0, 0, 0);
        csr_wr(1, 8'hf8);
        for (int i = 0; i < 2; i++) window(20, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(3, 0) == 0) csr_wr(2, $urandom_range(150, 20));
            window($urandom_range(150, 0), 0, 0, 0);
        end

        // stall detection with interrupt, retry and W1C
        csr_wr(0, 8'h09);
        for (int i = 0; i < 2; i++) window(10, 0, 0, 0);
        for (int i = 0; i < 3; i++) window(0, 0, 0, 0);
        csr_rd_chk("ctrl_stall", BASE, 8'h0d);
        csr_wr(0, 8'h0d);
        repeat (2) @(negedge clk);
        chk("w1c_irq", int'(irq), 0);
        csr_rd_chk("ctrl_after_w1c", BASE, 8'h09);

        // W1C coincident with a new stall
        for (int i = 0; i < 2; i++) window(10, 0, 0, 0);
        window(0, 0, 0, 0);
        window(0, 0, 0, 0);
        window(0, 2, 0, 8'h0d);
        csr_rd_chk("ctrl_set_wins", BASE, 8'h0d);

        // EN=0 written in the strobe cycle
        csr_wr(0, 8'h0d);
        for (int i = 0; i < 2; i++) window(20, 0, 0, 0);
        window(15, 1, 0, 8'h08);
        window(25, 0, 0, 0);

        // reset while running
        csr_wr(0, 8'h01);
        for (int i = 0; i < 3; i++) window(30, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        #1;
        chk("midrun_rst_en", int'(pwm_en), 0);
        chk("midrun_rst_duty", int'(pwm_duty), 0);
        for (int i = 0; i < 4; i++) csr_rd_chk("midrun_rst_reg", BASE + 5'(i), 0);
        window(20, 0, 0, 0);
        window(20, 0, 0, 0);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
